// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types, sizes and coefficients for the binary FIR block filter
package fir_pkg;

    typedef logic signed [31:0] sample_t;

    typedef enum logic [1:0] {
        OP_IDLE    = 2'b00,
        OP_LOAD    = 2'b01,
        OP_COMPUTE = 2'b10,
        OP_READ    = 2'b11
    } op_t;

    localparam int N_TAPS       = 10;
    localparam int SIGNAL_COUNT = 10;

    localparam sample_t FIR_COEFF [N_TAPS] = '{
        32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5,
        32'sd6, 32'sd7, 32'sd8, 32'sd9, 32'sd10
    };

endpackage

// File: rtl/fir_mac.sv
// rtl/fir_mac.sv - combinational dot product of the tap vector with the coefficients
module fir_mac
    import fir_pkg::*;
#(
    parameter int n = N_TAPS
) (
    input  sample_t i_taps [n],
    output sample_t o_sum
);

    sample_t w_acc;

    // Products and the running sum both wrap at 32 bits; no saturation.
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < n; i++) begin
            w_acc = w_acc + i_taps[i] * FIR_COEFF[i];
        end
    end

    assign o_sum = w_acc;

endmodule

// File: rtl/fir_srg_filter.sv
// rtl/fir_srg_filter.sv - block FIR filter: sample buffer, tap shift register, result buffer
module fir_srg_filter
    import fir_pkg::*;
#(
    parameter int n           = N_TAPS,
    parameter int signalCount = SIGNAL_COUNT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] x,
    input  logic [1:0]  operation,
    output logic [31:0] y,
    output logic        done
);

    localparam int IW = (signalCount > 1) ? $clog2(signalCount) : 1;
    localparam int CW = $clog2(signalCount + 1);

    sample_t        r_samples [signalCount];
    sample_t        r_results [signalCount];
    sample_t        r_taps    [n];
    logic [CW-1:0]  r_cnt;
    logic           r_done;

    sample_t        w_new_taps [n];
    sample_t        w_sum;
    sample_t        w_y;
    op_t            w_op;
    logic           w_addr_ok;
    logic           w_cnt_ok;
    logic [IW-1:0]  w_addr_idx;
    logic [IW-1:0]  w_cnt_idx;

    assign w_op       = op_t'(operation);
    assign w_addr_ok  = (addr < 32'(signalCount));
    assign w_cnt_ok   = (r_cnt < CW'(signalCount));
    assign w_addr_idx = addr[IW-1:0];
    assign w_cnt_idx  = r_cnt[IW-1:0];

    // The MAC sees the post-shift tap contents, so result[cnt] includes sample[cnt].
    always_comb begin
        for (int i = 0; i < n; i++) begin
            w_new_taps[i] = '0;
        end
        w_new_taps[0] = w_cnt_ok ? r_samples[w_cnt_idx] : '0;
        for (int i = 1; i < n; i++) begin
            w_new_taps[i] = r_taps[i-1];
        end
    end

    fir_mac #(.n(n)) u_mac (
        .i_taps (w_new_taps),
        .o_sum  (w_sum)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < signalCount; i++) begin
                r_samples[i] <= '0;
                r_results[i] <= '0;
            end
            for (int i = 0; i < n; i++) begin
                r_taps[i] <= '0;
            end
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            case (w_op)
                OP_IDLE, OP_LOAD: begin
                    if (w_op == OP_LOAD && w_addr_ok) begin
                        r_samples[w_addr_idx] <= x;
                    end
                    for (int i = 0; i < n; i++) begin
                        r_taps[i] <= '0;
                    end
                    r_cnt  <= '0;
                    r_done <= 1'b0;
                end
                OP_COMPUTE: begin
                    if (!r_done && w_cnt_ok) begin
                        for (int i = 0; i < n; i++) begin
                            r_taps[i] <= w_new_taps[i];
                        end
                        r_results[w_cnt_idx] <= w_sum;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(signalCount - 1)) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_y = '0;
        if (reset && w_op == OP_READ && w_addr_ok) begin
            w_y = r_results[w_addr_idx];
        end
    end

    assign y    = w_y;
    assign done = r_done;

endmodule

// File: tb/tb_fir_srg_filter.sv
// tb/tb_fir_srg_filter.sv - self-checking bench with a convolution reference model
module tb_fir_srg_filter;

    localparam int NT = 10;
    localparam int SC = 10;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] x;
    logic [1:0]  operation;
    logic [31:0] y;
    logic        done;

    int n_checks;
    int n_errors;
    int m_samples [SC];
    int edges;

    fir_srg_filter #(.n(NT), .signalCount(SC)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .x         (x),
        .operation (operation),
        .y         (y),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Direct convolution with h[i] = i+1; int arithmetic wraps like the hardware.
    function automatic int model_y(input int c);
        int acc;
        acc = 0;
        for (int i = 0; i < NT; i++) begin
            if (c - i >= 0) acc = acc + (i + 1) * m_samples[c - i];
        end
        return acc;
    endfunction

    task automatic load_block();
        operation = 2'b01;
        for (int a = 0; a < SC; a++) begin
            addr = a;
            x    = m_samples[a];
            step();
        end
        addr = SC;
        x    = 32'd99;
        step();
        operation = 2'b00;
        step();
    endtask

    task automatic run_compute(input string tag);
        operation = 2'b10;
        edges = 0;
        do begin
            step();
            edges++;
            if (edges < SC) check({tag, "_done_early"}, {31'd0, done}, 32'd0);
        end while (!done && edges < 3 * SC);
        check({tag, "_done_edges"}, edges, SC);
        check({tag, "_y_in_compute"}, y, 32'd0);
        step();
        check({tag, "_done_hold"}, {31'd0, done}, 32'd1);
    endtask

    task automatic read_all(input string tag);
        operation = 2'b11;
        for (int a = 0; a <= SC; a++) begin
            addr = a;
            #1;
            check($sformatf("%s_y%0d", tag, a), y, (a < SC) ? model_y(a) : 32'd0);
        end
        check({tag, "_done_in_read"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int ramp_exp [SC];
        ramp_exp = '{0, 1, 4, 10, 20, 35, 56, 84, 120, 165};
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < SC; i++) m_samples[i] = 0;

        reset = 1'b0; operation = 2'b01; addr = 0; x = 32'd55;
        step();
        step();
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_y_load", y, 32'd0);
        operation = 2'b11;
        #1;
        check("rst_y_read", y, 32'd0);
        reset = 1'b1; operation = 2'b11; addr = 0;
        #1;
        check("read_before_compute", y, 32'd0);
        operation = 2'b00;
        step();
        run_compute("zero");
        read_all("zero");

        for (int i = 0; i < SC; i++) m_samples[i] = i;
        load_block();
        run_compute("ramp");
        read_all("ramp");
        operation = 2'b11;
        for (int a = 0; a < SC; a++) begin
            addr = a;
            #1;
            check($sformatf("ramp_table_y%0d", a), y, ramp_exp[a]);
        end
        operation = 2'b00;
        step();
        check("idle_clears_done", {31'd0, done}, 32'd0);

        for (int i = 0; i < SC; i++) m_samples[i] = (i == 0) ? 1 : 0;
        load_block();
        run_compute("impulse");
        read_all("impulse");

        for (int i = 0; i < SC; i++) m_samples[i] = (i == 0) ? -1 : 0;
        load_block();
        run_compute("neg_impulse");
        read_all("neg_impulse");

        for (int i = 0; i < SC; i++) m_samples[i] = 32'h7FFF_FFFF;
        load_block();
        run_compute("maxpos");
        read_all("maxpos");
        operation = 2'b11; addr = 1;
        #1;
        check("maxpos_wrap_y1", y, 32'h7FFF_FFFD);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < SC; i++) m_samples[i] = $urandom;
            load_block();
            run_compute($sformatf("rand%0d", r));
            read_all($sformatf("rand%0d", r));
        end

        for (int i = 0; i < SC; i++) m_samples[i] = i;
        load_block();
        operation = 2'b10;
        for (int k = 0; k < 4; k++) step();
        check("abort_done_mid", {31'd0, done}, 32'd0);
        operation = 2'b01; addr = SC; x = 32'd7;
        step();
        check("abort_done_after", {31'd0, done}, 32'd0);
        run_compute("restart");
        read_all("restart");

        reset = 1'b0; operation = 2'b10;
        step();
        reset = 1'b1; operation = 2'b11; addr = 3;
        #1;
        check("reset_clears_results", y, 32'd0);
        check("reset_clears_done", {31'd0, done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fir_srg_filter.md
Name: fir_srg_filter

Overview:
- Block-level FIR filter built on a tap shift register. It buffers a block of `signalCount` input samples and computes `n`-tap FIR outputs over that block.
- Results are held in an output buffer and read back by address.
- Sits under the FIR top-level sequencer, which drives `operation`/`addr`/`x` and polls `done`.
- It is the binary (non-RNS) counterpart of the RNS filter and has an identical port contract.

Parameters:
- n, 10, number of FIR taps (coefficients h[0..n-1]).
- signalCount, 10, number of samples per block; also the size of the sample and result buffers.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- addr  input  32  sample write index (load) / result read index (readback).
- x  input  32  signed input sample.
- operation  input  2  00 idle, 01 load, 10 compute, 11 readback.
- y  output  32  signed filter output for result[addr].
- done  output  1  compute-complete flag.

Behaviour:
- Reset (`reset`=0 at a clk edge):
  - Clears the sample buffer, result buffer, tap shift register (n entries), compute counter and `done`.
  - `y` reads 0 during and after reset.
- Coefficients: constants from the package, default h[i] = i+1 (1..10), signed 32-bit.
- Op 00 (idle): no state change except `done` <= 0, counter <= 0, shift register cleared.
- Op 01 (load):
  - Each edge with addr < signalCount writes sample[addr] <= x.
  - addr >= signalCount is ignored, with no write and no wrap.
  - `done` <= 0, counter <= 0, shift register cleared.
- Op 10 (compute, while `done`=0), one sample per edge:
  - Shift register shifts by one and sample[cnt] enters tap 0.
  - result[cnt] <= sum over i of h[i] * tap_i, where tap_i is the new shift-register content, i.e. x[cnt-i], with zero for cnt-i < 0.
  - cnt <= cnt+1.
  - On the edge that writes result[signalCount-1], `done` <= 1.
  - `done` is therefore high after exactly signalCount edges in op 10.
- Op 10 with `done`=1: hold; no further writes.
- Op 11 (readback):
  - `y` = result[addr], combinational, if addr < signalCount; otherwise `y` = 0.
  - `done` holds its value.
  - Buffers are unchanged.
- `y` = 0 in ops 00, 01 and 10.
- Arithmetic:
  - Signed 32x32 products truncated to 32 bits.
  - Accumulation modulo 2^32; no saturation.
- Boundaries:
  - Op changing 10 -> 01/00 mid-compute aborts: counter and shift register cleared, partial results retained but stale, `done` stays 0.
  - Re-entering 10 restarts from cnt = 0.
  - Reset mid-operation takes priority over everything and clears all state.
  - Op 11 before any compute reads zeros.

Decomposition:
- Package fir_pkg:
  - `sample_t` (signed 32-bit).
  - `op_t` enum (`OP_IDLE`, `OP_LOAD`, `OP_COMPUTE`, `OP_READ`).
  - Coefficient array constant `FIR_COEFF`.
  - Default `N_TAPS` / `SIGNAL_COUNT`.
- One sub-module is natural: fir_mac.
  - A combinational n-input dot product of the tap vector with the coefficients.
  - Shared with the RNS variant's structure.

Test Plan:
1. Reset held low for 2 edges while op=01 and x=55 -> `done`=0, `y`=0, and no sample is written (later readback of index 0 after compute of zeros gives 0).
2. Load samples 0..9 at addr 0..9, plus an extra write at addr=10 with x=99 -> the addr=10 write is ignored. Op 10 -> `done` rises exactly 10 edges later.
3. After scenario 2, op 11 with addr 0..9 -> `y` = 0, 1, 4, 10, 20, 35, 56, 84, 120, 165. addr=10 -> `y`=0.
4. Load impulse (sample[0]=1, rest 0), compute, read -> `y` = 1, 2, 3, ..., 10 (the coefficients).
5. Load sample[0]=-1, rest 0 -> readback `y` = -1, -2, ..., -10. Load all samples 0x7FFFFFFF -> result[1] = 3*0x7FFFFFFF mod 2^32 = 0x7FFFFFFD.
6. Switch op 10 -> 01 after 4 compute edges, then back to 10 -> `done`=0 until 10 fresh edges complete. Results then match scenario 3.
